// File: rtl/stripes_pkg.sv
// Shared definitions for the bit-serial to bit-parallel detransposer.
//   state_t         : collector state (COLLECT accepts slices, HOLD parks a
//                     completed brick while the output register is occupied)
//   *_DEFAULT       : default word length, lane count and bit-counter width
//   BRICK_W_DEFAULT : width of one brick (WORDS x WL bits) at the defaults
//   brick_width()   : brick width for an arbitrary WL / WORDS pair
package stripes_pkg;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  localparam int WL_DEFAULT       = 16;
  localparam int WORDS_DEFAULT    = 16;
  localparam int CNT_BITS_DEFAULT = 4;
  localparam int BRICK_W_DEFAULT  = WL_DEFAULT * WORDS_DEFAULT;

  function automatic int brick_width(input int wl, input int words);
    return wl * words;
  endfunction

endpackage

// File: rtl/detransposer_lane.sv
// One serial lane of the detransposer: collects the bits of a single word.
// Optional feature macro: STRIPES_DETRANSPOSE_PREC_EN (adds the prec input and
// sign extension of the word above bit prec).
// Ports:
//   clk, rst : clock, asynchronous active-high reset (clears the accumulator)
//   we       : a slice is accepted this cycle; bit_in lands at bit position cnt
//   cnt      : bit position of the current slice
//   bit_in   : this lane's bit of the current slice
//   prec     : (macro only) index of the word's top valid bit, <= WL-1
//   word     : accumulator with the current bit merged in (when we) and,
//              with the macro, sign-extended above bit prec
module detransposer_lane
  import stripes_pkg::*;
#(
  parameter int WL       = WL_DEFAULT,
  parameter int CNT_BITS = CNT_BITS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [CNT_BITS-1:0] cnt,
  input  logic                bit_in,
`ifdef STRIPES_DETRANSPOSE_PREC_EN
  input  logic [CNT_BITS-1:0] prec,
`endif
  output logic [WL-1:0]       word
);

  logic [WL-1:0] acc;
  logic [WL-1:0] merged;

  // Accumulator: decode cnt into a one-hot write enable for the incoming bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (we) begin
      for (int k = 0; k < WL; k++) begin
        if (cnt == CNT_BITS'(k)) begin
          acc[k] <= bit_in;
        end
      end
    end
  end

  // Bypass the current bit so a completed brick can leave on the same edge
  // its last slice arrives.
  always_comb begin
    merged = acc;
    for (int k = 0; k < WL; k++) begin
      if (we && (cnt == CNT_BITS'(k))) begin
        merged[k] = bit_in;
      end else begin
        merged[k] = acc[k];
      end
    end
  end

`ifdef STRIPES_DETRANSPOSE_PREC_EN
  // Bits above prec are stale from earlier bricks; replace them with the sign bit.
  always_comb begin
    word = merged;
    for (int k = 0; k < WL; k++) begin
      if (CNT_BITS'(k) > prec) begin
        word[k] = merged[prec];
      end else begin
        word[k] = merged[k];
      end
    end
  end
`else
  // Full-length words only: no extension.
  always_comb begin
    word = merged;
  end
`endif

endmodule

// File: rtl/detransposer.sv
// Bit-serial to bit-parallel collector. WORDS lanes deliver one bit per word
// per cycle, LSB first; after WL accepted slices the brick is presented on a
// valid/ready output. A second completed brick can be parked (HOLD) while the
// output is stalled, so back-to-back bricks flow without bubbles.
// Optional feature macro: STRIPES_DETRANSPOSE_PREC_EN -- adds i_prec; each
// brick then ends after i_prec+1 slices (i_prec sampled on the first slice)
// and every word is sign-extended from bit i_prec. i_prec must be <= WL-1.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   i_valid  : i_stream holds a valid bit slice
//   o_ready  : collector accepts a slice this cycle (COLLECT state)
//   i_stream : bit slice, lane j = current bit of word j
//   i_prec   : (macro only) precision-1 of the brick
//   o_valid  : o_data holds a complete brick
//   i_ready  : downstream accepts o_data this cycle
//   o_data   : completed brick, word j at o_data[j*WL +: WL]
module detransposer
  import stripes_pkg::*;
#(
  parameter int WL       = WL_DEFAULT,
  parameter int WORDS    = WORDS_DEFAULT,
  parameter int CNT_BITS = CNT_BITS_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [WORDS-1:0]       i_stream,
`ifdef STRIPES_DETRANSPOSE_PREC_EN
  input  logic [CNT_BITS-1:0]    i_prec,
`endif
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [WL*WORDS-1:0]    o_data
);

  localparam int BRICK_W = brick_width(WL, WORDS);

  state_t              state;
  state_t              next_state;
  logic [CNT_BITS-1:0] cnt;
  logic [CNT_BITS-1:0] last_idx;
  logic                accept;
  logic                last;
  logic                out_free;
  logic                load_out;
  logic                next_valid;
  logic [BRICK_W-1:0]  brick;

`ifdef STRIPES_DETRANSPOSE_PREC_EN
  logic [CNT_BITS-1:0] prec_q;
  logic [CNT_BITS-1:0] prec_cur;

  // On the first slice of a brick the precision comes straight from i_prec;
  // afterwards (and in HOLD) the sampled copy is used.
  always_comb begin
    if ((state == COLLECT) && (cnt == '0)) begin
      prec_cur = i_prec;
    end else begin
      prec_cur = prec_q;
    end
  end

  // Capture the brick precision with its first slice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prec_q <= '0;
    end else if (accept && (cnt == '0)) begin
      prec_q <= i_prec;
    end
  end

  assign last_idx = prec_cur;
`else
  assign last_idx = CNT_BITS'(WL - 1);
`endif

  // o_ready depends on the state register only.
  assign o_ready  = (state == COLLECT);
  assign accept   = i_valid && o_ready;
  assign last     = accept && (cnt == last_idx);
  assign out_free = !o_valid || i_ready;

  for (genvar j = 0; j < WORDS; j++) begin : g_lane
    detransposer_lane #(
      .WL       (WL),
      .CNT_BITS (CNT_BITS)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .we     (accept),
      .cnt    (cnt),
      .bit_in (i_stream[j]),
`ifdef STRIPES_DETRANSPOSE_PREC_EN
      .prec   (prec_cur),
`endif
      .word   (brick[j*WL +: WL])
    );
  end

  // Next-state and output-load decisions.
  always_comb begin
    next_state = state;
    load_out   = 1'b0;
    case (state)
      COLLECT: begin
        if (last) begin
          if (out_free) begin
            load_out   = 1'b1;
            next_state = COLLECT;
          end else begin
            next_state = HOLD;
          end
        end else begin
          next_state = COLLECT;
        end
      end
      HOLD: begin
        if (i_ready) begin
          load_out   = 1'b1;
          next_state = COLLECT;
        end else begin
          next_state = HOLD;
        end
      end
      default: begin
        next_state = COLLECT;
      end
    endcase
    if (load_out) begin
      next_valid = 1'b1;
    end else begin
      next_valid = o_valid && !i_ready;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= next_state;
    end
  end

  // Bit counter: advances per accepted slice, wraps after the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= last ? '0 : (cnt + CNT_BITS'(1));
    end
  end

  // Output register: o_data changes only when a brick is loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      o_valid <= next_valid;
      if (load_out) begin
        o_data <= brick;
      end
    end
  end

endmodule

// File: tb/tb_detransposer.sv
// Self-checking bench for detransposer: a behavioural model assembles bricks
// from accepted slices and keeps a queue of completed, not-yet-consumed
// bricks; its size determines o_valid (>0) and o_ready (<2), and its head is
// the brick o_data must show when downstream consumes it.
module tb_detransposer;

  localparam int WL    = 16;
  localparam int WORDS = 16;
  localparam int CB    = 4;
  localparam int BW    = WL * WORDS;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_valid;
  logic              o_ready;
  logic [WORDS-1:0]  i_stream;
`ifdef STRIPES_DETRANSPOSE_PREC_EN
  logic [CB-1:0]     i_prec;
`endif
  logic              o_valid;
  logic              i_ready = 1'b1;
  logic [BW-1:0]     o_data;

  int errors = 0;
  int checks = 0;

  // model state
  logic [WL-1:0] part [WORDS];
  int            mcnt = 0;
  int            mprec = WL - 1;
  logic [BW-1:0] exp_q [$];
  logic [BW-1:0] prev_data;
  bit            prev_hold = 1'b0;
  int            consumed = 0;
  bit            ready_dropped = 1'b0;
  int            ready_mode = 0;   // 0: i_ready=1, 1: i_ready=0, 2: random

  logic [WL-1:0] cur_words [WORDS];

  detransposer #(.WL(WL), .WORDS(WORDS), .CNT_BITS(CB)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_stream (i_stream),
`ifdef STRIPES_DETRANSPOSE_PREC_EN
    .i_prec   (i_prec),
`endif
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_data   (o_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [WL-1:0] sext(input logic [WL-1:0] w, input int p);
    logic [WL-1:0] r;
    for (int k = 0; k < WL; k++) r[k] = (k > p) ? w[p] : w[k];
    return r;
  endfunction

  function automatic logic [BW-1:0] pack_words();
    logic [BW-1:0] b;
    for (int j = 0; j < WORDS; j++) b[j*WL +: WL] = cur_words[j];
    return b;
  endfunction

  // downstream ready driver
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       i_ready = 1'b1;
      1:       i_ready = 1'b0;
      default: i_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // model update and per-cycle compare, evaluated for the coming posedge
  always @(negedge clk) begin
    logic [BW-1:0] b;
    bit            ready_m;
    if (rst) begin
      exp_q.delete();
      mcnt = 0;
      for (int j = 0; j < WORDS; j++) part[j] = '0;
      prev_hold = 1'b0;
    end else begin
      ready_m = (exp_q.size() < 2);
      chk("o_valid", BW'(o_valid), BW'(exp_q.size() > 0));
      chk("o_ready", BW'(o_ready), BW'(ready_m));
      if (prev_hold) chk("o_data_stable", o_data, prev_data);
      if (!o_ready) ready_dropped = 1'b1;
      if ((exp_q.size() > 0) && i_ready) begin
        chk("o_data", o_data, exp_q[0]);
        void'(exp_q.pop_front());
        consumed++;
      end
      if (i_valid && ready_m) begin
        if (mcnt == 0) begin
`ifdef STRIPES_DETRANSPOSE_PREC_EN
          mprec = int'(i_prec);
`else
          mprec = WL - 1;
`endif
        end
        for (int j = 0; j < WORDS; j++) part[j][mcnt] = i_stream[j];
        if (mcnt == mprec) begin
          for (int j = 0; j < WORDS; j++) b[j*WL +: WL] = sext(part[j], mprec);
          exp_q.push_back(b);
          for (int j = 0; j < WORDS; j++) part[j] = '0;
          mcnt = 0;
        end else begin
          mcnt++;
        end
      end
      prev_hold = o_valid && !i_ready;
      prev_data = o_data;
    end
  end

  // Send nsl slices of cur_words; each slice retried until accepted.
  task automatic send_brick(input int nsl, input int prec, input int gap_pct);
    for (int b = 0; b < nsl; b++) begin
      bit done  = 1'b0;
      int waits = 0;
      while (!done) begin
        @(posedge clk); #1;
        i_valid = ($urandom_range(0, 99) >= gap_pct);
        for (int j = 0; j < WORDS; j++)
          i_stream[j] = i_valid ? cur_words[j][b] : 1'($urandom_range(0, 1));
`ifdef STRIPES_DETRANSPOSE_PREC_EN
        i_prec = (b == 0) ? CB'(prec) : CB'($urandom_range(0, 15));
`endif
        @(negedge clk);
        if (i_valid && o_ready) begin
          done = 1'b1;
        end else if (++waits > 1000) begin
          errors++;
          $display("FAIL slice_timeout: slice %0d not accepted, required within 1000 cycles", b);
          return;
        end
      end
    end
    if (prec < 0) $display("unexpected prec %0d", prec);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      i_valid = 1'b0;
    end
  endtask

  task automatic set_pattern();
    for (int j = 0; j < WORDS; j++) cur_words[j] = 16'hA5A0 + 16'(j);
  endtask

  task automatic set_random();
    for (int j = 0; j < WORDS; j++) cur_words[j] = 16'($urandom);
  endtask

  initial begin
    logic [BW-1:0] lit;
    logic [BW-1:0] b2;
    int            c0;
    rst = 1'b1; i_valid = 1'b0; i_stream = '0;
`ifdef STRIPES_DETRANSPOSE_PREC_EN
    i_prec = 4'd15;
`endif
    for (int j = 0; j < WORDS; j++) lit[j*WL +: WL] = 16'hA5A0 + 16'(j);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_o_valid", BW'(o_valid), BW'(1'b0));
    chk("reset_o_data", o_data, '0);
    chk("reset_o_ready", BW'(o_ready), BW'(1'b1));

    // single brick, literal pattern
    set_pattern();
    send_brick(WL, 15, 0);
    idle(1);
    @(negedge clk);
    chk("single_valid", BW'(o_valid), BW'(1'b1));
    chk("single_data", o_data, lit);
    idle(3);

    // reset mid-brick with an output brick pending
    ready_mode = 1;
    set_random();
    send_brick(WL, 15, 0);
    send_brick(5, 15, 0);
    @(posedge clk); #1;
    rst = 1'b1; i_valid = 1'b0;
    @(negedge clk);
    chk("midrst_o_valid", BW'(o_valid), BW'(1'b0));
    chk("midrst_o_data", o_data, '0);
    chk("midrst_o_ready", BW'(o_ready), BW'(1'b1));
    @(posedge clk); #1;
    rst = 1'b0; ready_mode = 0;
    set_pattern();
    send_brick(WL, 15, 0);
    idle(1);
    @(negedge clk);
    chk("after_rst_data", o_data, lit);
    idle(3);

    // back-to-back, i_ready held high
    ready_dropped = 1'b0;
    c0 = consumed;
    for (int n = 0; n < 3; n++) begin
      set_random();
      send_brick(WL, 15, 0);
    end
    idle(4);
    chk("b2b_ready_never_dropped", BW'(ready_dropped), BW'(1'b0));
    chk("b2b_bricks_out", BW'(consumed - c0), BW'(3));

    // backpressure across two bricks
    ready_mode = 1;
    set_pattern();
    send_brick(WL, 15, 0);
    set_random();
    b2 = pack_words();
    send_brick(WL, 15, 0);
    idle(2);
    @(negedge clk);
    chk("bp_hold_ready", BW'(o_ready), BW'(1'b0));
    chk("bp_hold_valid", BW'(o_valid), BW'(1'b1));
    chk("bp_first_data", o_data, lit);
    @(posedge clk); #1;
    ready_mode = 0;
    @(negedge clk);
    chk("bp_first_still", o_data, lit);
    @(negedge clk);
    chk("bp_second_data", o_data, b2);
    chk("bp_ready_back", BW'(o_ready), BW'(1'b1));
    idle(3);

    // same words without and with 50% i_valid gaps, then random soak
    set_random();
    send_brick(WL, 15, 0);
    send_brick(WL, 15, 50);
    ready_mode = 2;
    for (int n = 0; n < 20; n++) begin
      set_random();
      send_brick(WL, 15, 50);
    end
    ready_mode = 0;
    idle(4);

`ifdef STRIPES_DETRANSPOSE_PREC_EN
    for (int j = 0; j < WORDS; j++) cur_words[j] = 16'h0085;
    send_brick(8, 7, 0);
    idle(1);
    @(negedge clk);
    for (int j = 0; j < WORDS; j++) lit[j*WL +: WL] = 16'hFF85;
    chk("prec7_neg", o_data, lit);
    for (int j = 0; j < WORDS; j++) cur_words[j] = 16'h0005;
    send_brick(8, 7, 0);
    idle(1);
    @(negedge clk);
    for (int j = 0; j < WORDS; j++) lit[j*WL +: WL] = 16'h0005;
    chk("prec7_pos", o_data, lit);
    ready_mode = 2;
    for (int n = 0; n < 10; n++) begin
      set_random();
      send_brick(n + 1, n, 30);
    end
    ready_mode = 0;
`endif

    idle(40);
    chk("drained", BW'(exp_q.size()), BW'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
